id_scoreboard: RTL
==================

// Module: id_scoreboard
// PURPOSE
//  Decode-stage hazard unit for the RV32IM pipeline. It replaces the fixed load-use check and the fixed exe/mem forwarding.
//  Tracks outstanding writes from long-latency ops (load, MUL/DIV) in a per-register pending-count scoreboard.
//  Selects operands from N priority-ordered forwarding sources and asserts stallreq_o to ctrl.
//  Sits between regfile read and id_exe; consumes rs1/rs2/rd from decode.
// PARAMETERS
//  XLEN   32  operand/data width
//  RAW    5   register address width (32 regs; x0 hard-wired zero)
//  NFWD   2   forwarding sources; index 0 = youngest = highest priority (exe=0, mem=1)
//  CNT_W  2   pending-counter width per register (max 2^CNT_W-1 outstanding writes per rd)
// PORTS
//  clk_i          in   1            clock
//  rst_i          in   1            synchronous active-high reset
//  flush_i        in   1            pipeline flush (branch/jump redirect)
//  rs1_i, rs2_i   in   RAW          source addresses from decode
//  rs1_re_i, rs2_re_i in 1          source read enables
//  reg1_rdata_i, reg2_rdata_i in XLEN regfile read data
//  issue_i        in   1            decode has a valid instruction to hand to id_exe
//  issue_rd_i     in   RAW          its destination
//  issue_long_i   in   1            the instruction is load/MUL/DIV (writes back via completion port)
//  fwd_we_i       in   NFWD         per-source write enable
//  fwd_waddr_i    in   NFWD*RAW     per-source write address, packed, source k at [k*RAW +: RAW]
//  fwd_wdata_i    in   NFWD*XLEN    per-source write data, packed likewise
//  cmp_we_i       in   1            long-op completion/writeback strobe
//  cmp_rd_i       in   RAW          completion destination
//  cmp_wdata_i    in   XLEN         completion data
//  op1_o, op2_o   out  XLEN         resolved operands
//  stallreq_o     out  1            hold IF/ID, bubble id_exe
//  busy_o         out  1            any long op outstanding
//  err_o          out  1            sticky: completion to register with count 0
//  stall_cnt_o    out  32           stall-cycle counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all counters 0, err_o=0, stall_cnt_o=0; outputs then follow combinational rules (stallreq_o=0, busy_o=0).
//  Operand select (comb, 0 latency), per port p: if !re or rs==0 -> 0.
//   Else the first k in 0..NFWD-1 with fwd_we_i[k] && waddr==rs supplies the operand.
//   Else if cmp_we_i && cmp_rd_i==rs -> cmp_wdata_i. Else regfile data.
//  Stall: stallreq_o=1 if any enabled nonzero rs has cnt[rs]!=0, unless cnt[rs]==1 && cmp_we_i && cmp_rd_i==rs
//   (same-cycle release, data forwarded from completion).
//   Also stallreq_o=1 if issue_i && issue_long_i && cnt[issue_rd_i] is saturated (all ones).
//  Accept = issue_i && !stallreq_o && !flush_i.
//  Counter update per register r!=0, each cycle:
//   +1 if accept && issue_long_i && issue_rd_i==r; -1 if cmp_we_i && cmp_rd_i==r && cnt[r]!=0.
//   Both together -> unchanged. x0 is never counted.
//  Completion with cnt==0: ignored (no underflow), err_o set until rst_i.
//  flush_i: all counters cleared next cycle; killed long ops never complete (upstream guarantee).
//   A completion in the flush cycle is dropped and does not set err_o.
//  busy_o = OR of all counters != 0 (registered state, not next-state).
//  Reset or flush mid-operation overrides all same-cycle increments/decrements.
// CONFIGURATION
//  ID_SB_STATS_EN defined:
//   stall_cnt_o increments by 1 each cycle stallreq_o=1 && !flush_i, saturating at 32'hFFFF_FFFF.
//   Cleared only by rst_i.
//  ID_SB_STATS_EN undefined: counter not built; stall_cnt_o tied to 32'd0.
// STRUCTURE
//  defines.v: ZERO_REG, ZERO, READ_ENABLE, WRITE_ENABLE reused; add SB_CNT_W default constant.
//  Sub-module id_fwd_mux (one per read port): priority mux over NFWD sources plus completion port.
//  Scoreboard counters, stall logic and stats stay in the top module.
// TESTING
//  1 rst_i 1 cycle, then idle -> stallreq_o=0, busy_o=0, err_o=0, op1_o=reg1_rdata_i.
//  2 fwd src0 and src1 both write x5 (0xAAAA / 0xBBBB), rs1=x5 -> op1_o=0xAAAA; rs1=x0 -> 0.
//  3 issue MUL rd=x7 (long); next rs2=x7 -> stallreq_o=1 until cmp_we_i x7=0x1234;
//    that cycle stallreq_o=0, op2_o=0x1234, cnt[x7]->0.
//  4 issue 3 long ops to x9 (CNT_W=2) -> 4th issue to x9 stalls; one completion -> 4th accepted.
//  5 pending x3 and x4, flush_i -> counters 0 next cycle, busy_o=0; completion on x3 in flush cycle does not set err_o.
//  6 cmp_we_i to x6 with cnt 0 -> err_o=1 sticky; with ID_SB_STATS_EN, 10 stall cycles -> stall_cnt_o=10.

Source files
------------

// File: rtl/id_scoreboard_pkg.sv
// Shared constants, types and helpers for the decode-stage scoreboard.
// Optional build macro: ID_SB_STATS_EN (stall-cycle statistics counter).
package id_scoreboard_pkg;

   localparam int XLEN     = 32;
   localparam int RAW      = 5;
   localparam int NFWD     = 2;
   localparam int SB_CNT_W = 2;
   localparam int CNT_W    = SB_CNT_W;
   localparam int NREG     = 1 << RAW;

   localparam logic [RAW-1:0]  ZERO_REG     = '0;
   localparam logic [XLEN-1:0] ZERO         = '0;
   localparam logic            READ_ENABLE  = 1'b1;
   localparam logic            WRITE_ENABLE = 1'b1;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [RAW-1:0]   reg_addr_t;
   typedef logic [XLEN-1:0]  word_t;

   localparam cnt_t CNT_MAX = '1;

   // A source port blocks decode when it reads a register with writes still in
   // flight, except for the last outstanding write completing this very cycle:
   // that value is picked up from the completion port by the operand mux.
   function automatic logic src_blocks(input logic      re,
                                       input reg_addr_t rs,
                                       input cnt_t      cnt,
                                       input logic      cmp_we,
                                       input reg_addr_t cmp_rd);
      logic pending;
      logic released;
      pending  = (re == READ_ENABLE) && (rs != ZERO_REG) && (cnt != '0);
      released = (cnt == cnt_t'(1)) && (cmp_we == WRITE_ENABLE) && (cmp_rd == rs);
      return pending && !released;
   endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// Decode/forwarding/completion bundle between the pipeline and the scoreboard.
// master = pipeline side driving requests, slave = scoreboard.
interface id_scoreboard_if
   import id_scoreboard_pkg::*;
   ;

   logic                 flush_i;
   reg_addr_t            rs1_i;
   reg_addr_t            rs2_i;
   logic                 rs1_re_i;
   logic                 rs2_re_i;
   word_t                reg1_rdata_i;
   word_t                reg2_rdata_i;
   logic                 issue_i;
   reg_addr_t            issue_rd_i;
   logic                 issue_long_i;
   logic [NFWD-1:0]      fwd_we_i;
   logic [NFWD*RAW-1:0]  fwd_waddr_i;
   logic [NFWD*XLEN-1:0] fwd_wdata_i;
   logic                 cmp_we_i;
   reg_addr_t            cmp_rd_i;
   word_t                cmp_wdata_i;
   word_t                op1_o;
   word_t                op2_o;
   logic                 stallreq_o;
   logic                 busy_o;
   logic                 err_o;
   logic [31:0]          stall_cnt_o;

   modport master (
      output flush_i, rs1_i, rs2_i, rs1_re_i, rs2_re_i,
             reg1_rdata_i, reg2_rdata_i,
             issue_i, issue_rd_i, issue_long_i,
             fwd_we_i, fwd_waddr_i, fwd_wdata_i,
             cmp_we_i, cmp_rd_i, cmp_wdata_i,
      input  op1_o, op2_o, stallreq_o, busy_o, err_o, stall_cnt_o
   );

   modport slave (
      input  flush_i, rs1_i, rs2_i, rs1_re_i, rs2_re_i,
             reg1_rdata_i, reg2_rdata_i,
             issue_i, issue_rd_i, issue_long_i,
             fwd_we_i, fwd_waddr_i, fwd_wdata_i,
             cmp_we_i, cmp_rd_i, cmp_wdata_i,
      output op1_o, op2_o, stallreq_o, busy_o, err_o, stall_cnt_o
   );

endinterface

// File: rtl/id_scoreboard_fwd_mux.sv
// Per-read-port operand selector: priority mux over the forwarding sources
// (index 0 youngest, highest priority), then the long-op completion port,
// then the register file. Disabled reads and x0 always yield zero.
module id_scoreboard_fwd_mux
   import id_scoreboard_pkg::*;
(
   input  logic                 re,
   input  reg_addr_t            rs,
   input  word_t                rdata,
   input  logic [NFWD-1:0]      fwd_we,
   input  logic [NFWD*RAW-1:0]  fwd_waddr,
   input  logic [NFWD*XLEN-1:0] fwd_wdata,
   input  logic                 cmp_we,
   input  reg_addr_t            cmp_rd,
   input  word_t                cmp_wdata,
   output word_t                op
);

   logic found;

   // Walk sources youngest-first; the first match wins, older ones are shadowed.
   always_comb begin
      op    = rdata;
      found = 1'b0;
      if (re != READ_ENABLE || rs == ZERO_REG) begin
         op    = ZERO;
         found = 1'b1;
      end else begin
         for (int k = 0; k < NFWD; k++) begin
            if (!found && fwd_we[k] == WRITE_ENABLE &&
                fwd_waddr[k*RAW +: RAW] == rs) begin
               op    = fwd_wdata[k*XLEN +: XLEN];
               found = 1'b1;
            end
         end
         if (!found && cmp_we == WRITE_ENABLE && cmp_rd == rs) begin
            op    = cmp_wdata;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage hazard unit: per-register pending-write counters for long-latency
// ops (load, MUL/DIV), operand forwarding and the stall request to ctrl.
// Optional build macro: ID_SB_STATS_EN adds a saturating stall-cycle counter;
// without it stall_cnt_o reads zero.
module id_scoreboard
   import id_scoreboard_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   id_scoreboard_if.slave   sb
);

   cnt_t cnt_q [NREG];
   cnt_t cnt_d [NREG];
   logic err_q;
   logic err_d;
   logic stall;
   logic accept;
   logic inc_any;
   logic dec_any;
   logic busy;

   id_scoreboard_fwd_mux u_mux1 (
      .re        (sb.rs1_re_i),
      .rs        (sb.rs1_i),
      .rdata     (sb.reg1_rdata_i),
      .fwd_we    (sb.fwd_we_i),
      .fwd_waddr (sb.fwd_waddr_i),
      .fwd_wdata (sb.fwd_wdata_i),
      .cmp_we    (sb.cmp_we_i),
      .cmp_rd    (sb.cmp_rd_i),
      .cmp_wdata (sb.cmp_wdata_i),
      .op        (sb.op1_o)
   );

   id_scoreboard_fwd_mux u_mux2 (
      .re        (sb.rs2_re_i),
      .rs        (sb.rs2_i),
      .rdata     (sb.reg2_rdata_i),
      .fwd_we    (sb.fwd_we_i),
      .fwd_waddr (sb.fwd_waddr_i),
      .fwd_wdata (sb.fwd_wdata_i),
      .cmp_we    (sb.cmp_we_i),
      .cmp_rd    (sb.cmp_rd_i),
      .cmp_wdata (sb.cmp_wdata_i),
      .op        (sb.op2_o)
   );

   // Stall on a RAW hazard against an outstanding long op, or when issuing a
   // long op whose destination counter has no room for another write.
   always_comb begin
      stall = 1'b0;
      if (src_blocks(sb.rs1_re_i, sb.rs1_i, cnt_q[sb.rs1_i], sb.cmp_we_i, sb.cmp_rd_i))
         stall = 1'b1;
      if (src_blocks(sb.rs2_re_i, sb.rs2_i, cnt_q[sb.rs2_i], sb.cmp_we_i, sb.cmp_rd_i))
         stall = 1'b1;
      if (sb.issue_i && sb.issue_long_i && cnt_q[sb.issue_rd_i] == CNT_MAX)
         stall = 1'b1;
   end

   // An instruction leaves decode only when nothing holds it and it is not
   // being killed by a redirect.
   always_comb begin
      accept  = sb.issue_i && !stall && !sb.flush_i;
      inc_any = accept && sb.issue_long_i && (sb.issue_rd_i != ZERO_REG);
      dec_any = sb.cmp_we_i && (sb.cmp_rd_i != ZERO_REG) && (cnt_q[sb.cmp_rd_i] != '0);
   end

   // Next counter values: flush wipes everything, a simultaneous issue and
   // completion on the same register cancel out, x0 is pinned at zero.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         if (r == 0 || sb.flush_i) begin
            cnt_d[r] = '0;
         end else if (inc_any && sb.issue_rd_i == RAW'(r) &&
                      !(dec_any && sb.cmp_rd_i == RAW'(r))) begin
            cnt_d[r] = cnt_q[r] + cnt_t'(1);
         end else if (dec_any && sb.cmp_rd_i == RAW'(r) &&
                      !(inc_any && sb.issue_rd_i == RAW'(r))) begin
            cnt_d[r] = cnt_q[r] - cnt_t'(1);
         end
      end
   end

   // A completion for a register with nothing outstanding is a protocol error;
   // completions during a flush belong to killed ops and are silently dropped.
   // x0 writebacks are never tracked, so they are not reported either.
   always_comb begin
      err_d = err_q;
      if (sb.cmp_we_i && !sb.flush_i && sb.cmp_rd_i != ZERO_REG &&
          cnt_q[sb.cmp_rd_i] == '0)
         err_d = 1'b1;
   end

   // Scoreboard state register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NREG; r++)
            cnt_q[r] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++)
            cnt_q[r] <= cnt_d[r];
         err_q <= err_d;
      end
   end

   // Busy reflects the registered counters, not the value about to be written.
   always_comb begin
      busy = 1'b0;
      for (int r = 0; r < NREG; r++)
         if (cnt_q[r] != '0)
            busy = 1'b1;
   end

   assign sb.stallreq_o = stall;
   assign sb.busy_o     = busy;
   assign sb.err_o      = err_q;

`ifdef ID_SB_STATS_EN
   logic [31:0] stall_cnt_q;

   // Count cycles spent stalled (flush cycles excluded), saturating at all ones.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         stall_cnt_q <= 32'd0;
      else if (stall && !sb.flush_i && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   assign sb.stall_cnt_o = stall_cnt_q;
`else
   assign sb.stall_cnt_o = 32'd0;
`endif

endmodule
